// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StReq     = 2'd1,
    StSquash  = 2'd2,
    StDeliver = 2'd3
  } fetch_state_e;

  // Instruction presented while nothing valid has been fetched.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte distance between sequential instructions.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter owner and single-outstanding-request fetch sequencer.
// Delivers each fetched word with its PC and PC+4 to decode, holds it across
// stalls, and squashes in-flight fetches when the next-PC logic redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Stall,
  input  logic              i_Redirect,
  input  logic [ADDR_W-1:0] i_Target,
  output logic              o_Fetch_Req,
  output logic [ADDR_W-1:0] o_Fetch_Addr,
  input  logic              i_Fetch_Ack,
  input  logic [31:0]       i_Fetch_Data,
  output logic              o_Instr_Valid,
  output logic [31:0]       o_Instruction,
  output logic [ADDR_W-1:0] o_Pc,
  output logic [ADDR_W-1:0] o_Pc_Plus4,
  output logic              o_Misaligned
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              misaligned_q, misaligned_d;

  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] fetch_pc_next;

  // Targets are word-aligned by dropping the low two bits; the add wraps.
  assign target_aligned = {i_Target[ADDR_W-1:2], 2'b00};
  assign fetch_pc_next  = fetch_pc_q + STEP;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= StBoot;
      fetch_pc_q   <= RESET_VECTOR;
      pend_pc_q    <= RESET_VECTOR;
      instr_q      <= NOP_INSTR;
      pc_q         <= RESET_VECTOR;
      pc_plus4_q   <= RESET_VECTOR + STEP;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Next-state logic and fetch request decode.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pc_plus4_d   = pc_plus4_q;
    o_Fetch_Req  = 1'b0;
    // Every redirect is accepted in every state, so flag it one cycle later.
    misaligned_d = i_Redirect & (|i_Target[1:0]);

    case (state_q)
      StBoot: begin
        if (i_Redirect) fetch_pc_d = target_aligned;
        state_d = StReq;
      end

      StReq: begin
        o_Fetch_Req = 1'b1;
        if (i_Redirect && i_Fetch_Ack) begin
          // Returned word is from the wrong path; refetch from the target.
          fetch_pc_d = target_aligned;
        end else if (i_Redirect) begin
          // Request address must stay stable until the ack, so park the target.
          pend_pc_d = target_aligned;
          state_d   = StSquash;
        end else if (i_Fetch_Ack) begin
          instr_d    = i_Fetch_Data;
          pc_d       = fetch_pc_q;
          pc_plus4_d = fetch_pc_next;
          fetch_pc_d = fetch_pc_next;
          state_d    = StDeliver;
        end
      end

      StSquash: begin
        o_Fetch_Req = 1'b1;
        if (i_Redirect) pend_pc_d = target_aligned;
        if (i_Fetch_Ack) begin
          // Newest redirect wins even if it arrives with the ack.
          fetch_pc_d = i_Redirect ? target_aligned : pend_pc_q;
          state_d    = StReq;
        end
      end

      StDeliver: begin
        if (i_Redirect) begin
          fetch_pc_d = target_aligned;
          state_d    = StReq;
        end else if (!i_Stall) begin
          state_d = StReq;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // Outputs come straight from registered state so they are glitch-free.
  always_comb begin
    o_Fetch_Addr  = fetch_pc_q;
    o_Instr_Valid = (state_q == StDeliver);
    o_Instruction = instr_q;
    o_Pc          = pc_q;
    o_Pc_Plus4    = pc_plus4_q;
    o_Misaligned  = misaligned_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        ack;
  logic [31:0] data;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        mis;

  // Second instance exercising the wrapping reset vector.
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_ack;
  logic [31:0] w_data;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_mis;

  int checks;
  int failures;

  fetch_sequencer #(
    .ADDR_W      (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Stall      (stall),
    .i_Redirect   (redirect),
    .i_Target     (target),
    .o_Fetch_Req  (req),
    .o_Fetch_Addr (addr),
    .i_Fetch_Ack  (ack),
    .i_Fetch_Data (data),
    .o_Instr_Valid(valid),
    .o_Instruction(instr),
    .o_Pc         (pc),
    .o_Pc_Plus4   (pc4),
    .o_Misaligned (mis)
  );

  fetch_sequencer #(
    .ADDR_W      (32),
    .RESET_VECTOR(32'hFFFF_FFFC)
  ) dut_w (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Stall      (w_stall),
    .i_Redirect   (w_redirect),
    .i_Target     (w_target),
    .o_Fetch_Req  (w_req),
    .o_Fetch_Addr (w_addr),
    .i_Fetch_Ack  (w_ack),
    .i_Fetch_Data (w_data),
    .o_Instr_Valid(w_valid),
    .o_Instruction(w_instr),
    .o_Pc         (w_pc),
    .o_Pc_Plus4   (w_pc4),
    .o_Misaligned (w_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    target     = 32'h0;
    ack        = 1'b0;
    data       = 32'h0;
    w_stall    = 1'b0;
    w_redirect = 1'b0;
    w_target   = 32'h0;
    w_ack      = 1'b0;
    w_data     = 32'h0;

    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc4, 32'h4);
    check("rst_mis", {31'b0, mis}, 32'd0);
    check("w_rst_pc", w_pc, 32'hFFFF_FFFC);
    check("w_rst_pc4", w_pc4, 32'h0);

    // Cycle 0: release reset, still booting.
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("boot_req", {31'b0, req}, 32'd0);

    // Cycle 1: first request, zero-wait ack.
    tick();
    ack = 1'b1; data = 32'hA000_0000;
    w_ack = 1'b1; w_data = 32'hCAFE_0001;
    @(negedge clk);
    check("c1_req", {31'b0, req}, 32'd1);
    check("c1_addr", addr, 32'h0);
    check("w_c1_addr", w_addr, 32'hFFFF_FFFC);

    // Cycle 2: deliver 0x0.
    tick();
    ack = 1'b0; w_ack = 1'b0;
    @(negedge clk);
    check("c2_valid", {31'b0, valid}, 32'd1);
    check("c2_req", {31'b0, req}, 32'd0);
    check("c2_pc", pc, 32'h0);
    check("c2_pc4", pc4, 32'h4);
    check("c2_instr", instr, 32'hA000_0000);
    check("w_c2_pc", w_pc, 32'hFFFF_FFFC);
    check("w_c2_pc4", w_pc4, 32'h0);
    check("w_c2_instr", w_instr, 32'hCAFE_0001);

    // Cycle 3/4: 0x4.
    tick();
    ack = 1'b1; data = 32'hA000_0004;
    @(negedge clk);
    check("c3_addr", addr, 32'h4);
    check("c3_valid", {31'b0, valid}, 32'd0);
    check("w_c3_addr", w_addr, 32'h0);
    tick();
    ack = 1'b0;
    @(negedge clk);
    check("c4_pc", pc, 32'h4);
    check("c4_pc4", pc4, 32'h8);
    check("c4_instr", instr, 32'hA000_0004);

    // Cycle 5/6: 0x8.
    tick();
    ack = 1'b1; data = 32'hA000_0008;
    @(negedge clk);
    check("c5_addr", addr, 32'h8);
    tick();
    ack = 1'b0;
    @(negedge clk);
    check("c6_valid", {31'b0, valid}, 32'd1);
    check("c6_pc", pc, 32'h8);
    check("c6_pc4", pc4, 32'hC);

    // Cycle 7/8: 0xC.
    tick();
    ack = 1'b1; data = 32'hA000_000C;
    @(negedge clk);
    check("c7_addr", addr, 32'hC);
    tick();
    ack = 1'b0;
    @(negedge clk);
    check("c8_pc", pc, 32'hC);

    // Cycle 9/10: 0x10, then stall for three cycles.
    tick();
    ack = 1'b1; data = 32'hA000_0010;
    @(negedge clk);
    check("c9_addr", addr, 32'h10);
    tick();
    ack = 1'b0; stall = 1'b1;
    @(negedge clk);
    check("c10_pc", pc, 32'h10);
    check("c10_instr", instr, 32'hA000_0010);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check("stall_valid", {31'b0, valid}, 32'd1);
      check("stall_req", {31'b0, req}, 32'd0);
      check("stall_pc", pc, 32'h10);
      check("stall_pc4", pc4, 32'h14);
      check("stall_instr", instr, 32'hA000_0010);
    end

    // Cycle 13: stall drops, handoff this cycle.
    tick();
    stall = 1'b0;
    @(negedge clk);
    check("c13_valid", {31'b0, valid}, 32'd1);
    check("c13_req", {31'b0, req}, 32'd0);

    // Cycle 14: request 0x14, redirect to 0x100 while waiting.
    tick();
    redirect = 1'b1; target = 32'h100;
    @(negedge clk);
    check("c14_req", {31'b0, req}, 32'd1);
    check("c14_addr", addr, 32'h14);

    // Cycles 15-16: squashing, address held.
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("c15_addr", addr, 32'h14);
    check("c15_valid", {31'b0, valid}, 32'd0);
    check("c15_mis", {31'b0, mis}, 32'd0);
    tick();
    @(negedge clk);
    check("c16_req", {31'b0, req}, 32'd1);
    check("c16_addr", addr, 32'h14);

    // Cycle 17: stale ack arrives and is discarded.
    tick();
    ack = 1'b1; data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("c17_addr", addr, 32'h14);

    // Cycle 18: request to 0x100; redirect to 0x103 coincides with ack.
    tick();
    ack = 1'b1; data = 32'hBAD0_0001; redirect = 1'b1; target = 32'h103;
    @(negedge clk);
    check("c18_valid", {31'b0, valid}, 32'd0);
    check("c18_addr", addr, 32'h100);

    // Cycle 19: refetch from aligned 0x100, misaligned pulse.
    tick();
    redirect = 1'b0; ack = 1'b1; data = 32'hA000_0100;
    @(negedge clk);
    check("c19_req", {31'b0, req}, 32'd1);
    check("c19_addr", addr, 32'h100);
    check("c19_valid", {31'b0, valid}, 32'd0);
    check("c19_mis", {31'b0, mis}, 32'd1);

    // Cycle 20: deliver 0x100; redirect overrides stall.
    tick();
    ack = 1'b0; stall = 1'b1; redirect = 1'b1; target = 32'h200;
    @(negedge clk);
    check("c20_valid", {31'b0, valid}, 32'd1);
    check("c20_pc", pc, 32'h100);
    check("c20_pc4", pc4, 32'h104);
    check("c20_instr", instr, 32'hA000_0100);
    check("c20_mis", {31'b0, mis}, 32'd0);

    // Cycle 21: request to redirect target despite the stall.
    tick();
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("c21_req", {31'b0, req}, 32'd1);
    check("c21_addr", addr, 32'h200);
    check("c21_valid", {31'b0, valid}, 32'd0);

    // Reset while the request is outstanding: request drops immediately.
    #2 rst = 1'b1;
    #1;
    check("arst_req", {31'b0, req}, 32'd0);
    check("arst_valid", {31'b0, valid}, 32'd0);
    tick();
    ack = 1'b1; data = 32'h5555_AAAA;
    @(negedge clk);
    check("arst_hold_req", {31'b0, req}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rel_req", {31'b0, req}, 32'd0);
    check("rel_valid", {31'b0, valid}, 32'd0);
    tick();
    ack = 1'b0;
    @(negedge clk);
    check("rel_c1_addr", addr, 32'h0);
    check("rel_c1_req", {31'b0, req}, 32'd1);
    check("rel_c1_valid", {31'b0, valid}, 32'd0);
    tick();
    ack = 1'b1; data = 32'h1234_5678;
    @(negedge clk);
    check("rel_c2_addr", addr, 32'h0);
    tick();
    ack = 1'b0;
    @(negedge clk);
    check("rel_c3_valid", {31'b0, valid}, 32'd1);
    check("rel_c3_pc", pc, 32'h0);
    check("rel_c3_instr", instr, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch from a single-port instruction memory, one outstanding request at a time.
- Delivers each fetched word, with its PC and PC+4, to decode, and holds it while decode stalls.
- Accepts redirects (taken branch or jump target) from the next-PC logic and squashes any in-flight fetch.
- Sits between the next-PC block, instruction memory and the hazard unit.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- ADDR_W, 32, PC/address width.

Ports:
- i_Clk  in  1  clock; all state changes on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Stall  in  1  decode cannot accept; hold the delivered instruction.
- i_Redirect  in  1  one-cycle pulse: next fetch comes from i_Target.
- i_Target  in  ADDR_W  redirect address (already computed branch/jump target).
- o_Fetch_Req  out  1  fetch request to instruction memory.
- o_Fetch_Addr  out  ADDR_W  fetch address; stable while o_Fetch_Req=1.
- i_Fetch_Ack  in  1  memory returns i_Fetch_Data this cycle.
- i_Fetch_Data  in  32  instruction word.
- o_Instr_Valid  out  1  o_Instruction/o_Pc valid.
- o_Instruction  out  32  delivered instruction.
- o_Pc  out  ADDR_W  address of o_Instruction.
- o_Pc_Plus4  out  ADDR_W  o_Pc+4, modulo 2^ADDR_W.
- o_Misaligned  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].

Behaviour:
- Reset (async, any state):
  - state=BOOT, fetch_pc=RESET_VECTOR.
  - o_Fetch_Req=0, o_Instr_Valid=0, o_Instruction=32'h0 (NOP).
  - o_Pc=RESET_VECTOR, o_Pc_Plus4=RESET_VECTOR+4, o_Misaligned=0.
- States: BOOT, REQ, SQUASH, DELIVER.
- BOOT: no request; goes to REQ on the first clock after reset release. A redirect in BOOT loads fetch_pc=target.
- REQ: o_Fetch_Req=1, o_Fetch_Addr=fetch_pc.
  - ack and no redirect: o_Instruction<=data, o_Pc<=fetch_pc, o_Pc_Plus4<=fetch_pc+4, fetch_pc<=fetch_pc+4, o_Instr_Valid<=1, go to DELIVER.
  - redirect and no ack: fetch_pc is not changed (address must stay stable); latch the target into pend_pc, go to SQUASH.
  - redirect and ack in the same cycle: discard data, fetch_pc<=target, stay in REQ. The next request goes to the target.
- SQUASH: o_Fetch_Req=1, address unchanged.
  - On ack: discard data, fetch_pc<=pend_pc, go to REQ.
  - A further redirect overwrites pend_pc (newest wins).
- DELIVER: o_Fetch_Req=0, o_Instr_Valid=1; outputs held stable.
  - redirect (overrides stall): o_Instr_Valid<=0, fetch_pc<=target, go to REQ.
  - otherwise !i_Stall (handoff this cycle): o_Instr_Valid<=0, go to REQ.
  - otherwise stay.
- Latency:
  - First request is in cycle 1 after reset release.
  - Ack in cycle k gives o_Instr_Valid in cycle k+1.
  - Zero-wait memory gives one instruction per 2 cycles.
- Target alignment:
  - The target is used with bits [1:0] forced to 0.
  - o_Misaligned pulses in the cycle after the redirect is accepted.
- Arithmetic: all PC adds are ADDR_W-bit and wrap; 0xFFFF_FFFC+4 = 0x0000_0000, with no flag.
- i_Fetch_Ack is ignored when o_Fetch_Req=0.
- Reset mid-fetch abandons the request: o_Fetch_Req drops asynchronously, and a later ack is ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (BOOT, REQ, SQUASH, DELIVER);
  - NOP_INSTR = 32'h0;
  - PC_STEP = 4.
- Single module; no sub-module warranted. The +4 adder and the alignment mask are inline.

Test Plan:
- Reset, then zero-wait memory (ack in the same cycle as req): requests go to 0x0, 0x4, 0x8 in cycles 1, 3, 5. o_Instr_Valid is high in cycles 2, 4, 6 with o_Pc=0x0/0x4/0x8 and o_Pc_Plus4=0x4/0x8/0xC.
- In DELIVER with o_Pc=0x10, hold i_Stall=1 for 3 cycles: outputs stable and o_Fetch_Req=0 throughout. The next request goes to 0x14 the cycle after i_Stall falls.
- Request to 0x20 with ack delayed 3 cycles; i_Redirect with i_Target=0x100 in cycle 1 of the wait. o_Fetch_Addr stays 0x20 until the ack, the acked data is never delivered, and the next request goes to 0x100.
- Redirect coincident with ack in REQ: data dropped and the next request goes to the target. A redirect to 0x103 fetches 0x100 and o_Misaligned pulses once.
- RESET_VECTOR=32'hFFFF_FFFC: first request to 0xFFFF_FFFC, o_Pc_Plus4=0x0000_0000, second request to 0x0.
- Assert i_Reset while waiting for an ack: o_Fetch_Req=0 and o_Instr_Valid=0 immediately (before the next edge). The stale ack is ignored, and after release the first request goes to RESET_VECTOR.
